// File: rtl/arb_pkg.sv
// arb_pkg: shared types and width defaults for mem_port_arbiter and arb_pick.
package arb_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} arb_state_t;
   typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner select between the I and D requesters.
// Ports: req_i/req_d requests in, last_owner previous grant in, owner winner out.
// Build option ARB_ROUND_ROBIN_EN: alternate on contention; otherwise D has fixed priority.
module arb_pick
   import arb_pkg::*;
(
   input  logic   req_i,
   input  logic   req_d,
   input  owner_t last_owner,
   output owner_t owner
);
   // With no request the output is never consumed; last_owner is a harmless filler.
`ifdef ARB_ROUND_ROBIN_EN
   assign owner = (req_i & req_d) ? ((last_owner == OWN_D) ? OWN_I : OWN_D) :
                  req_d ? OWN_D : req_i ? OWN_I : last_owner;
`else
   assign owner = req_d ? OWN_D : req_i ? OWN_I : last_owner;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (I) and load/store (D).
// Ports: clk, rst (sync, active-low); I side if_read/if_addr -> if_rdata/if_resp;
// D side d_read/d_write/d_addr/d_wdata/d_wmask -> d_rdata/d_resp; memory side
// mem_read/mem_write/mem_address/mem_wdata/mem_byte_enable <- mem_rdata/mem_resp;
// addr_sel (0 = I owner, 1 = D owner). Build option ARB_ROUND_ROBIN_EN selects arbitration.
module mem_port_arbiter #(
   parameter int ADDR_W = arb_pkg::ADDR_W,
   parameter int DATA_W = arb_pkg::DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_read,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_resp,
   input  logic                d_read,
   input  logic                d_write,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wmask,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_resp,
   output logic                mem_read,
   output logic                mem_write,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_byte_enable,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_resp,
   output logic                addr_sel
);
   import arb_pkg::*;
   arb_state_t state;
   owner_t     last_owner, win;
   logic       req_d, win_d;
   assign req_d = d_read | d_write;
   assign win_d = (win == OWN_D);
   arb_pick u_pick (.req_i(if_read), .req_d(req_d), .last_owner(last_owner), .owner(win));
   // Responses are combinational from mem_resp; a reset cycle swallows any in-flight completion.
   assign if_resp  = rst & mem_resp & (state == BUSY_I);
   assign d_resp   = rst & mem_resp & (state == BUSY_D);
   assign if_rdata = mem_rdata;
   assign d_rdata  = mem_rdata;
   always_ff @(posedge clk)
      if (!rst) begin
         state           <= IDLE;
         mem_read        <= 1'b0;
         mem_write       <= 1'b0;
         addr_sel        <= 1'b0;
         mem_address     <= '0;
         mem_wdata       <= '0;
         mem_byte_enable <= '0;
         last_owner      <= OWN_D;
      end else
         case (state)
            IDLE: if (if_read | req_d) begin
               state           <= win_d ? BUSY_D : BUSY_I;
               last_owner      <= win;
               addr_sel        <= win_d;
               mem_address     <= win_d ? d_addr : if_addr;
               mem_read        <= ~win_d | ~d_write;
               mem_write       <= win_d & d_write;
               mem_wdata       <= win_d ? d_wdata : mem_wdata;
               mem_byte_enable <= (win_d & d_write) ? d_wmask : '1;
            end
            BUSY_I, BUSY_D: if (mem_resp) begin
               state     <= DONE;
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
            end
            default: state <= IDLE;
         endcase
endmodule
